// File: rtl/display_pkg.sv
// Shared types and constants for the 74HC595 hex display driver.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high {g,f,e,d,c,b,a} codes, indexed by nibble value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_display_595_hex_to_7seg.sv
// Combinational nibble to 7-segment code lookup.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; every nibble value has an entry.
  always_comb begin
    seg = SEG_LUT[nibble];
  end

endmodule

// File: rtl/hex_display_595.sv
// Shows a 32-bit word as 8 hex digits through a chain of eight 74HC595s.
// Optional macro HEX_DISPLAY_BLANK_LEADING_ZEROS_EN blanks leading zero digits.
module hex_display_595
  import display_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    sr_clk_o,
  output logic                    sr_data_o,
  output logic                    sr_latch_o,
  output logic                    sr_oe_n_o
);

  localparam int FRAME_W = 8 * NUM_DIGITS;
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [5:0]       LAST_BIT = 6'(FRAME_W - 1);

  logic [6:0]            seg_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_s;
  logic [FRAME_W-1:0]    frame_s;
  logic                  accept_s;

  state_e             state_r,    state_next_s;
  logic [DIV_W-1:0]   div_cnt_r,  div_cnt_next_s;
  logic [5:0]         bit_cnt_r,  bit_cnt_next_s;
  logic [FRAME_W-1:0] shreg_r,    shreg_next_s;
  logic               sr_clk_r,   sr_clk_next_s;
  logic               sr_data_r,  sr_data_next_s;
  logic               latch_r,    latch_next_s;
  logic               oe_n_r,     oe_n_next_s;
  logic               ready_r,    ready_next_s;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      hex_to_7seg u_seg (
        .nibble (data_i[4*g +: 4]),
        .seg    (seg_s[g])
      );
    end
  endgenerate

`ifdef HEX_DISPLAY_BLANK_LEADING_ZEROS_EN
  logic nz_seen_s;

  // A digit is blank when it and every digit above it is zero; digit 0 always shows.
  always_comb begin
    nz_seen_s = 1'b0;
    blank_s   = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      nz_seen_s  = nz_seen_s | (data_i[4*k +: 4] != 4'h0);
      blank_s[k] = ~nz_seen_s;
    end
  end
`else
  // Every digit shows its hex code.
  always_comb begin
    blank_s = '0;
  end
`endif

  // Assemble the 64-bit frame; the DP bit survives blanking.
  always_comb begin
    frame_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (blank_s[k]) begin
        frame_s[8*k +: 8] = {dp_i[k], SEG_BLANK[6:0]};
      end else begin
        frame_s[8*k +: 8] = {dp_i[k], seg_s[k]};
      end
    end
  end

  assign accept_s = valid_i & ready_r;

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_next_s   = state_r;
    div_cnt_next_s = div_cnt_r;
    bit_cnt_next_s = bit_cnt_r;
    shreg_next_s   = shreg_r;
    sr_clk_next_s  = sr_clk_r;
    sr_data_next_s = sr_data_r;
    latch_next_s   = latch_r;
    oe_n_next_s    = oe_n_r;
    ready_next_s   = ready_r;

    case (state_r)
      IDLE: begin
        div_cnt_next_s = '0;
        bit_cnt_next_s = 6'd0;
        sr_clk_next_s  = 1'b0;
        latch_next_s   = 1'b0;
        if (accept_s) begin
          state_next_s   = SHIFT_LO;
          shreg_next_s   = frame_s;
          sr_data_next_s = frame_s[FRAME_W-1];
          ready_next_s   = 1'b0;
        end else begin
          sr_data_next_s = 1'b0;
          ready_next_s   = 1'b1;
        end
      end

      SHIFT_LO: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_next_s = '0;
          state_next_s   = SHIFT_HI;
          sr_clk_next_s  = 1'b1;
        end else begin
          div_cnt_next_s = div_cnt_r + DIV_ONE;
        end
      end

      SHIFT_HI: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_next_s = '0;
          shreg_next_s   = {shreg_r[FRAME_W-2:0], 1'b0};
          bit_cnt_next_s = bit_cnt_r + 6'd1;
          sr_clk_next_s  = 1'b0;
          if (bit_cnt_r < LAST_BIT) begin
            state_next_s   = SHIFT_LO;
            sr_data_next_s = shreg_r[FRAME_W-2];
          end else begin
            state_next_s = LATCH;
            latch_next_s = 1'b1;
          end
        end else begin
          div_cnt_next_s = div_cnt_r + DIV_ONE;
        end
      end

      LATCH: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_next_s = '0;
          state_next_s   = IDLE;
          latch_next_s   = 1'b0;
          sr_data_next_s = 1'b0;
          oe_n_next_s    = 1'b0;
          ready_next_s   = 1'b1;
        end else begin
          div_cnt_next_s = div_cnt_r + DIV_ONE;
        end
      end

      default: begin
        state_next_s   = IDLE;
        div_cnt_next_s = '0;
        bit_cnt_next_s = 6'd0;
        sr_clk_next_s  = 1'b0;
        sr_data_next_s = 1'b0;
        latch_next_s   = 1'b0;
        ready_next_s   = 1'b1;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      div_cnt_r <= '0;
      bit_cnt_r <= 6'd0;
      shreg_r   <= '0;
      sr_clk_r  <= 1'b0;
      sr_data_r <= 1'b0;
      latch_r   <= 1'b0;
      oe_n_r    <= 1'b1;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      div_cnt_r <= div_cnt_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      shreg_r   <= shreg_next_s;
      sr_clk_r  <= sr_clk_next_s;
      sr_data_r <= sr_data_next_s;
      latch_r   <= latch_next_s;
      oe_n_r    <= oe_n_next_s;
      ready_r   <= ready_next_s;
    end
  end

  assign ready_o    = ready_r;
  assign busy_o     = ~ready_r;
  assign sr_clk_o   = sr_clk_r;
  assign sr_data_o  = sr_data_r;
  assign sr_latch_o = latch_r;
  assign sr_oe_n_o  = oe_n_r;

endmodule

// File: tb/tb_hex_display_595.sv
// Directed self-checking bench for hex_display_595 (CLK_DIV=2).
module tb_hex_display_595;

  localparam int CLK_DIV  = 2;
  localparam int BUSY_CYC = 129 * CLK_DIV;

  localparam logic [63:0] EXP_BASIC = 64'h065B4F666D7D077F;
  localparam logic [63:0] EXP_FF_DP = 64'h71717171717171F1;
`ifdef HEX_DISPLAY_BLANK_LEADING_ZEROS_EN
  localparam logic [63:0] EXP_A0   = 64'h000000000000773F;
  localparam logic [63:0] EXP_ZERO = 64'h000000000000003F;
`else
  localparam logic [63:0] EXP_A0   = 64'h3F3F3F3F3F3F773F;
  localparam logic [63:0] EXP_ZERO = 64'h3F3F3F3F3F3F3F3F;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic        valid_i;
  logic        ready_o, busy_o, sr_clk_o, sr_data_o, sr_latch_o, sr_oe_n_o;

  int checks   = 0;
  int failures = 0;

  logic [63:0] cap_r        = 64'h0;
  int          edge_cnt     = 0;
  int          latch_pulses = 0;
  int          latch_hi     = 0;

  hex_display_595 #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .dp_i       (dp_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .sr_clk_o   (sr_clk_o),
    .sr_data_o  (sr_data_o),
    .sr_latch_o (sr_latch_o),
    .sr_oe_n_o  (sr_oe_n_o)
  );

  always #5 clk = ~clk;

  // Model of the 595 chain input: shift SER in on every SRCLK rising edge.
  always @(posedge sr_clk_o) begin
    cap_r    <= {cap_r[62:0], sr_data_o};
    edge_cnt <= edge_cnt + 1;
  end

  always @(posedge sr_latch_o) begin
    latch_pulses <= latch_pulses + 1;
  end

  always @(posedge clk) begin
    if (sr_latch_o) latch_hi <= latch_hi + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready_o !== 1'b1 && cyc < 2000) begin
      step(1);
      cyc++;
    end
  endtask

  // Checks a completed frame against counters snapshotted at its accept.
  task automatic check_frame(input string tag, input int cyc, input int e0, input int l0,
                             input int h0, input logic [63:0] exp);
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(BUSY_CYC));
    check({tag, "_sr_clk_edges"}, 64'(edge_cnt - e0), 64'd64);
    check({tag, "_bytes"}, cap_r, exp);
    check({tag, "_latch_pulses"}, 64'(latch_pulses - l0), 64'd1);
    check({tag, "_latch_width"}, 64'(latch_hi - h0), 64'(CLK_DIV));
    check({tag, "_oe_n_after"}, 64'(sr_oe_n_o), 64'd0);
    check({tag, "_data_idle"}, 64'(sr_data_o), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] d, input logic [7:0] dp,
                           input logic [63:0] exp);
    int e0, l0, h0, cyc;
    e0 = edge_cnt;
    l0 = latch_pulses;
    h0 = latch_hi;
    data_i  = d;
    dp_i    = dp;
    valid_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    check({tag, "_ready_drop"}, 64'(ready_o), 64'd0);
    check({tag, "_busy_rise"}, 64'(busy_o), 64'd1);
    wait_ready(cyc);
    check_frame(tag, cyc, e0, l0, h0, exp);
  endtask

  initial begin
    int e0, l0, h0, cyc;

    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = 32'h0;
    dp_i    = 8'h0;
    step(3);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_sr_clk", 64'(sr_clk_o), 64'd0);
    check("rst_sr_data", 64'(sr_data_o), 64'd0);
    check("rst_latch", 64'(sr_latch_o), 64'd0);
    check("rst_oe_n", 64'(sr_oe_n_o), 64'd1);

    rst_i = 1'b0;
    e0 = edge_cnt;
    step(20);
    check("idle_no_edges", 64'(edge_cnt - e0), 64'd0);
    check("idle_oe_n", 64'(sr_oe_n_o), 64'd1);

    run_frame("basic", 32'h12345678, 8'h00, EXP_BASIC);

    // Frame 1 with valid_i held and data switched to 0 right after accept.
    e0 = edge_cnt;
    l0 = latch_pulses;
    h0 = latch_hi;
    data_i  = 32'hFFFFFFFF;
    dp_i    = 8'h01;
    valid_i = 1'b1;
    step(1);
    data_i = 32'h0;
    dp_i   = 8'h00;
    check("busy1_ready_drop", 64'(ready_o), 64'd0);
    wait_ready(cyc);
    check_frame("busy1", cyc, e0, l0, h0, EXP_FF_DP);

    // Held request is taken on the first ready cycle.
    e0 = edge_cnt;
    l0 = latch_pulses;
    h0 = latch_hi;
    step(1);
    valid_i = 1'b0;
    check("busy2_accept_next", 64'(ready_o), 64'd0);
    wait_ready(cyc);
    check_frame("busy2", cyc, e0, l0, h0, EXP_ZERO);

    run_frame("lz_a0", 32'h000000A0, 8'h00, EXP_A0);
    run_frame("lz_zero", 32'h00000000, 8'h00, EXP_ZERO);

    // Reset after the 20th SRCLK rising edge of a frame.
    e0 = edge_cnt;
    l0 = latch_pulses;
    data_i  = 32'h89ABCDEF;
    dp_i    = 8'hFF;
    valid_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    cyc = 0;
    while ((edge_cnt - e0) < 20 && cyc < 2000) begin
      step(1);
      cyc++;
    end
    check("mid_edges_reached", 64'(edge_cnt - e0), 64'd20);
    rst_i = 1'b1;
    step(1);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_sr_clk", 64'(sr_clk_o), 64'd0);
    check("mid_rst_sr_data", 64'(sr_data_o), 64'd0);
    check("mid_rst_latch", 64'(sr_latch_o), 64'd0);
    check("mid_rst_oe_n", 64'(sr_oe_n_o), 64'd1);
    step(2);
    rst_i = 1'b0;
    step(10);
    check("mid_no_latch", 64'(latch_pulses - l0), 64'd0);
    check("mid_no_more_edges", 64'(edge_cnt - e0), 64'd20);
    check("mid_oe_n_stays", 64'(sr_oe_n_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
